// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and constants for the USB transmit arbiter.
//                Holds the arbiter state encoding, the handshake/data PID
//                values used by the packet sources, and the default timing
//                parameters for the inter-packet gap and strobe watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    // Arbiter state encoding (explicit 3-bit width).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEND  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    // PID bytes as they appear on the wire (PID plus its check nibble).
    localparam logic [7:0] c_PID_ACK   = 8'hD2;
    localparam logic [7:0] c_PID_NAK   = 8'h5A;
    localparam logic [7:0] c_PID_STALL = 8'h1E;
    localparam logic [7:0] c_PID_DATA0 = 8'hC3;
    localparam logic [7:0] c_PID_DATA1 = 8'h4B;

    // Default timing parameters.
    localparam int c_GAP_CYCLES_DEF     = 8;
    localparam int c_TIMEOUT_CYCLES_DEF = 1023;

endpackage
`default_nettype wire

// File: rtl/usb_tx_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_rr_pick
//  Description : Combinational winner picker. Request 0 wins outright when
//                asserted; otherwise requests 1..NUM_REQ-1 are searched
//                round-robin starting just after the last granted index.
//  Ports       : i_req      - request vector
//                i_last_ptr - index of the last granted round-robin requester
//                o_grant    - one-hot winner (all zero when nothing requests)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_rr_pick
    import usb_tx_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_last_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;

    // Two passes give the wrap-around search: first the indices above the
    // pointer, then the indices from 1 up to and including the pointer.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        if (i_req[0]) begin
            o_grant[0] = 1'b1;
            w_found    = 1'b1;
        end
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i > int'(i_last_ptr))) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i <= int'(i_last_ptr))) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_arbiter
//  Description : Shares the ULPI handshake multiplexer transmit channel
//                between NUM_REQ packet sources. Arbitrates (requester 0
//                has priority, the rest round-robin), frames each packet
//                with start/stop pulses, returns per-byte ready strobes to
//                the owner, enforces an inter-packet gap and a no-strobe
//                watchdog.
//  Ports       : USB_CLKIN       - 60 MHz ULPI clock
//                NRST            - asynchronous active-low reset
//                rq_valid_i/rq_data_i/rq_last_i - requester byte lanes
//                rq_grant_o      - one-hot channel owner
//                rq_ready_o      - byte consumed (combinational from strobe)
//                rq_done_o       - packet closed normally
//                rq_fail_o       - packet aborted
//                tx_data_o/tx_start_stop_o - to the multiplexer
//                tx_strb_i/tx_fail_i       - from the multiplexer
//                busy_o          - arbiter not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int GAP_CYCLES     = c_GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
    input  logic                   USB_CLKIN,
    input  logic                   NRST,
    input  logic [NUM_REQ-1:0]     rq_valid_i,
    input  logic [8*NUM_REQ-1:0]   rq_data_i,
    input  logic [NUM_REQ-1:0]     rq_last_i,
    output logic [NUM_REQ-1:0]     rq_grant_o,
    output logic [NUM_REQ-1:0]     rq_ready_o,
    output logic [NUM_REQ-1:0]     rq_done_o,
    output logic [NUM_REQ-1:0]     rq_fail_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_stop_o,
    input  logic                   tx_strb_i,
    input  logic                   tx_fail_i,
    output logic                   busy_o
);

    localparam int         c_PTR_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [9:0] c_TIMEOUT  = 10'(TIMEOUT_CYCLES);
    localparam logic [7:0] c_GAP_LAST = 8'(GAP_CYCLES - 1);

    tx_state_e            r_state;
    tx_state_e            w_next;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_pick;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   w_pick_idx;
    logic [7:0]           r_gap_cnt;
    logic [9:0]           r_wdog_cnt;
    logic                 r_pkt_fail;
    logic [NUM_REQ-1:0]   r_dn_fail;

    logic [7:0]           w_lane;
    logic                 w_g_valid;
    logic                 w_g_last;
    logic                 w_any_req;
    logic                 w_dn_fail;
    logic                 w_accept;
    logic                 w_underrun;
    logic                 w_timeout;

    usb_tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_pick (
        .i_req      (rq_valid_i),
        .i_last_ptr (r_rr_ptr),
        .o_grant    (w_pick)
    );

    // Granted-lane selection and winner index for the round-robin pointer.
    always_comb begin
        w_lane     = '0;
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_lane = w_lane | rq_data_i[8*i +: 8];
            end
            if (w_pick[i]) begin
                w_pick_idx = c_PTR_W'(i);
            end
        end
    end

    // Event decode. A downstream fail beats a simultaneous strobe, and a
    // strobe beats a simultaneous watchdog expiry.
    always_comb begin
        w_any_req  = |rq_valid_i;
        w_g_valid  = |(rq_valid_i & r_grant);
        w_g_last   = |(rq_last_i & r_grant);
        w_dn_fail  = tx_fail_i && ((r_state == ST_START) || (r_state == ST_SEND));
        w_accept   = (r_state == ST_SEND) && tx_strb_i && !tx_fail_i && w_g_valid;
        w_underrun = (r_state == ST_SEND) && tx_strb_i && !tx_fail_i && !w_g_valid;
        w_timeout  = (r_state == ST_SEND) && !tx_strb_i && !tx_fail_i &&
                     (r_wdog_cnt == c_TIMEOUT);
    end

    // State register.
    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and framing outputs.
    always_comb begin
        w_next          = r_state;
        rq_grant_o      = r_grant;
        rq_ready_o      = '0;
        rq_done_o       = '0;
        rq_fail_o       = r_dn_fail;
        tx_data_o       = 8'h00;
        tx_start_stop_o = 1'b0;
        busy_o          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                tx_start_stop_o = 1'b1;
                tx_data_o       = w_lane;
                w_next          = w_dn_fail ? ST_GAP : ST_SEND;
            end
            ST_SEND: begin
                tx_data_o = w_lane;
                if (w_accept) begin
                    rq_ready_o = r_grant;
                end
                if (w_dn_fail) begin
                    w_next = ST_GAP;
                end else if ((w_accept && w_g_last) || w_underrun || w_timeout) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_start_stop_o = 1'b1;
                if (r_pkt_fail) begin
                    rq_fail_o = rq_fail_o | r_grant;
                end else begin
                    rq_done_o = r_grant;
                end
                w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant, pointer, failure flags and counters.
    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            r_grant    <= '0;
            r_rr_ptr   <= c_PTR_W'(1);
            r_pkt_fail <= 1'b0;
            r_dn_fail  <= '0;
            r_wdog_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant <= w_pick;
                // Requester 0 is outside the rotation, so it leaves the
                // pointer alone.
                if (!w_pick[0]) begin
                    r_rr_ptr <= w_pick_idx;
                end
            end else if ((w_next == ST_GAP) && (r_state != ST_GAP)) begin
                r_grant <= '0;
            end

            if (r_state == ST_START) begin
                r_pkt_fail <= 1'b0;
            end else if (w_underrun || w_timeout) begin
                r_pkt_fail <= 1'b1;
            end

            // The grant clears on the same edge, so the owner is latched
            // here to produce the fail pulse one cycle later.
            r_dn_fail <= w_dn_fail ? r_grant : '0;

            if ((r_state == ST_START) || tx_strb_i) begin
                r_wdog_cnt <= '0;
            end else if ((r_state == ST_SEND) && (r_wdog_cnt != c_TIMEOUT)) begin
                r_wdog_cnt <= r_wdog_cnt + 10'd1;
            end

            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_tx_arbiter
//  Description : Self-checking bench for usb_tx_arbiter. Requesters are
//                modelled as byte buffers; expected grants, bytes and packet
//                endings are queued when packets are loaded and consumed as
//                the arbiter produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_arbiter;
    import usb_tx_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int GAP     = 8;
    localparam int TMO     = 1023;

    localparam logic [1:0] K_DONE  = 2'd0;
    localparam logic [1:0] K_FSTOP = 2'd1;
    localparam logic [1:0] K_FDN   = 2'd2;

    typedef struct packed { logic [1:0] req; logic [7:0] data; } byte_t;
    typedef struct packed { logic [1:0] kind; logic [1:0] req; } end_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   rq_valid_i;
    logic [8*NUM_REQ-1:0] rq_data_i;
    logic [NUM_REQ-1:0]   rq_last_i;
    logic [NUM_REQ-1:0]   rq_grant_o, rq_ready_o, rq_done_o, rq_fail_o;
    logic [7:0]           tx_data_o;
    logic                 tx_start_stop_o;
    logic                 tx_strb_i;
    logic                 tx_fail_i;
    logic                 busy_o;

    always #5 clk = ~clk;

    usb_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .USB_CLKIN       (clk),
        .NRST            (rst_n),
        .rq_valid_i      (rq_valid_i),
        .rq_data_i       (rq_data_i),
        .rq_last_i       (rq_last_i),
        .rq_grant_o      (rq_grant_o),
        .rq_ready_o      (rq_ready_o),
        .rq_done_o       (rq_done_o),
        .rq_fail_o       (rq_fail_o),
        .tx_data_o       (tx_data_o),
        .tx_start_stop_o (tx_start_stop_o),
        .tx_strb_i       (tx_strb_i),
        .tx_fail_i       (tx_fail_i),
        .busy_o          (busy_o)
    );

    // Requester buffers
    logic [7:0] src_mem    [NUM_REQ][8];
    int         src_len    [NUM_REQ];
    int         src_pos    [NUM_REQ];
    bit         src_nolast [NUM_REQ];

    // Scoreboard
    byte_t exp_byte_q [$];
    byte_t exp_grant_q[$];
    end_t  exp_end_q  [$];
    int    start_hist [$];
    int    stop_hist  [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int fail_cyc = -1;
    bit auto_strb = 1'b1;
    bit in_pkt = 1'b0;
    bit was_busy = 1'b0;
    bit obs_busy;
    logic [NUM_REQ-1:0] obs_valid;
    int start_cyc, stop_cyc, last_ready_cyc, idle_cyc, dnfail_cyc, t_load;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_lanes();
        for (int n = 0; n < NUM_REQ; n++) begin
            if (src_pos[n] < src_len[n]) begin
                rq_valid_i[n]       = 1'b1;
                rq_data_i[8*n +: 8] = src_mem[n][src_pos[n]];
                rq_last_i[n]        = (src_pos[n] == src_len[n] - 1) && !src_nolast[n];
            end else begin
                rq_valid_i[n]       = 1'b0;
                rq_data_i[8*n +: 8] = 8'h00;
                rq_last_i[n]        = 1'b0;
            end
        end
        tx_strb_i = auto_strb;
        tx_fail_i = (cyc == fail_cyc);
    endtask

    task automatic load(input int n, input int len, input logic [63:0] bytes, input bit nolast);
        for (int k = 0; k < 8; k++) src_mem[n][k] = bytes[63-8*k -: 8];
        src_len[n]    = len;
        src_pos[n]    = 0;
        src_nolast[n] = nolast;
    endtask

    task automatic expect_pkt(input int n, input int n_bytes, input logic [1:0] kind);
        byte_t b;
        end_t  e;
        b.req = 2'(n);
        b.data = src_mem[n][0];
        exp_grant_q.push_back(b);
        for (int k = 0; k < n_bytes; k++) begin
            b.data = src_mem[n][k];
            exp_byte_q.push_back(b);
        end
        e.kind = kind;
        e.req  = 2'(n);
        exp_end_q.push_back(e);
    endtask

    // One clock cycle: drive, check outputs mid-cycle, let requesters
    // consume on the edge, return at the next falling edge.
    task automatic cycle();
        byte_t b;
        end_t  e;
        logic [NUM_REQ-1:0] rdy, fl;
        drive_lanes();
        #1;
        rdy = rq_ready_o;
        fl  = rq_fail_o;
        obs_busy  = busy_o;
        obs_valid = rq_valid_i;
        if (rdy != '0) begin
            last_ready_cyc = cyc;
            if (exp_byte_q.size() == 0) chk("ready_unexpected", 32'(rdy), 0);
            else begin
                b = exp_byte_q.pop_front();
                chk("ready_req", 32'(rdy), 32'(1) << b.req);
                chk("tx_byte", 32'(tx_data_o), 32'(b.data));
            end
        end
        if (tx_start_stop_o) begin
            if (!in_pkt) begin
                in_pkt = 1'b1;
                start_cyc = cyc;
                start_hist.push_back(cyc);
                if (exp_grant_q.size() == 0) chk("start_unexpected", 32'(tx_start_stop_o), 0);
                else begin
                    b = exp_grant_q.pop_front();
                    chk("start_grant", 32'(rq_grant_o), 32'(1) << b.req);
                    chk("start_pid", 32'(tx_data_o), 32'(b.data));
                end
            end else begin
                in_pkt = 1'b0;
                stop_cyc = cyc;
                stop_hist.push_back(cyc);
                chk("stop_data", 32'(tx_data_o), 0);
            end
        end
        if ((rq_done_o != '0) || (fl != '0)) begin
            if (exp_end_q.size() == 0) chk("end_unexpected", 32'({rq_done_o, fl}), 0);
            else begin
                e = exp_end_q.pop_front();
                chk("done_vec", 32'(rq_done_o), (e.kind == K_DONE) ? (32'(1) << e.req) : 0);
                chk("fail_vec", 32'(fl), (e.kind != K_DONE) ? (32'(1) << e.req) : 0);
                chk("end_stop_pulse", 32'(tx_start_stop_o), 32'(e.kind != K_FDN));
                if (e.kind == K_FDN) begin
                    in_pkt = 1'b0;
                    dnfail_cyc = cyc;
                end
            end
        end
        if (obs_busy) was_busy = 1'b1;
        else if (was_busy) begin
            was_busy = 1'b0;
            idle_cyc = cyc;
        end
        @(posedge clk);
        for (int n = 0; n < NUM_REQ; n++) begin
            if (rdy[n]) src_pos[n]++;
            if (fl[n]) src_len[n] = src_pos[n];  // owner abandons the packet
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_quiet(input int max, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            cycle();
            if (!obs_busy && (obs_valid == '0)) done = 1'b1;
        end
        if (!done) chk({tag, "_quiet_timeout"}, 32'(obs_busy), 0);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_bytes_left"}, exp_byte_q.size(), 0);
        chk({tag, "_starts_left"}, exp_grant_q.size(), 0);
        chk({tag, "_ends_left"}, exp_end_q.size(), 0);
    endtask

    function automatic logic [31:0] outvec();
        return 32'({rq_grant_o, rq_ready_o, rq_done_o, rq_fail_o, tx_data_o, tx_start_stop_o, busy_o});
    endfunction

    initial begin
        rst_n = 1'b0;
        rq_valid_i = '0; rq_data_i = '0; rq_last_i = '0;
        tx_strb_i = 1'b0; tx_fail_i = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            src_len[n] = 0; src_pos[n] = 0; src_nolast[n] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", outvec(), 0);
        rst_n = 1'b1;

        // 1: single-byte handshake from requester 0
        t_load = cyc;
        load(0, 1, {c_PID_ACK, 56'h0}, 1'b0);
        expect_pkt(0, 1, K_DONE);
        run_quiet(40, "t1");
        chk("t1_valid_to_start", start_cyc - t_load, 1);
        chk("t1_strobe_to_stop", stop_cyc - last_ready_cyc, 1);
        chk("t1_stop_to_idle", idle_cyc - stop_cyc, GAP + 1);
        drained("t1");

        // 2: DATA0 packet from requester 1
        load(1, 6, {c_PID_DATA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'h0}, 1'b0);
        expect_pkt(1, 6, K_DONE);
        run_quiet(60, "t2");
        drained("t2");

        // 4: underrun on requester 2 after three bytes
        load(2, 3, {c_PID_DATA1, 8'h21, 8'h22, 40'h0}, 1'b1);
        expect_pkt(2, 3, K_FSTOP);
        run_quiet(60, "t4");
        drained("t4");

        // 3: contention, all three valid together (last RR grant was 2)
        start_hist.delete(); stop_hist.delete();
        load(1, 2, {c_PID_DATA1, 8'hB1, 48'h0}, 1'b0);
        load(2, 2, {c_PID_DATA0, 8'hC2, 48'h0}, 1'b0);
        load(0, 2, {c_PID_DATA0, 8'hA0, 48'h0}, 1'b0);
        expect_pkt(0, 2, K_DONE);
        expect_pkt(1, 2, K_DONE);
        expect_pkt(2, 2, K_DONE);
        run_quiet(120, "t3");
        chk("t3_spacing_0_1", start_hist[1] - stop_hist[0], GAP + 2);
        chk("t3_spacing_1_2", start_hist[2] - stop_hist[1], GAP + 2);
        drained("t3");

        // 5a: watchdog, no strobes at all
        auto_strb = 1'b0;
        load(1, 2, {c_PID_DATA0, 8'h11, 48'h0}, 1'b0);
        expect_pkt(1, 0, K_FSTOP);
        run_quiet(1200, "t5a");
        chk("t5a_start_to_stop", stop_cyc - start_cyc, TMO + 2);
        drained("t5a");
        auto_strb = 1'b1;

        // 5b: downstream fail coinciding with the third strobe
        t_load = cyc;
        fail_cyc = t_load + 4;
        load(0, 4, {c_PID_DATA1, 8'h11, 8'h22, 8'h33, 32'h0}, 1'b0);
        expect_pkt(0, 2, K_FDN);
        run_quiet(60, "t5b");
        fail_cyc = -1;
        chk("t5b_fail_pulse_cycle", dnfail_cyc - t_load, 5);
        chk("t5b_gap_to_idle", idle_cyc - dnfail_cyc, GAP);
        drained("t5b");

        // 3 repeat: requesters 1 and 2 only (last RR grant was 1)
        load(1, 2, {c_PID_DATA1, 8'hB1, 48'h0}, 1'b0);
        load(2, 2, {c_PID_DATA0, 8'hC2, 48'h0}, 1'b0);
        expect_pkt(2, 2, K_DONE);
        expect_pkt(1, 2, K_DONE);
        run_quiet(80, "t3r");
        drained("t3r");

        // 6: reset in the middle of a packet
        load(1, 8, {c_PID_DATA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0);
        expect_pkt(1, 8, K_DONE);
        repeat (4) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", outvec(), 0);
        exp_byte_q.delete(); exp_grant_q.delete(); exp_end_q.delete();
        in_pkt = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) src_len[n] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("t6_idle_after_reset", 32'(busy_o), 0);
        load(1, 2, {c_PID_DATA1, 8'hB1, 48'h0}, 1'b0);
        load(2, 2, {c_PID_DATA0, 8'hC2, 48'h0}, 1'b0);
        load(0, 1, {c_PID_NAK, 56'h0}, 1'b0);
        expect_pkt(0, 1, K_DONE);
        expect_pkt(2, 2, K_DONE);
        expect_pkt(1, 2, K_DONE);
        run_quiet(120, "t6");
        drained("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
